// File: rtl/forward_ctrl.sv
// Forwarding and load-use hazard control for the EX-stage operand muxes.
// Optional perf counters (stall_cnt, fwd_cnt) are built when FWD_PERF_CNT_EN is defined.
module forward_ctrl #(
    parameter int unsigned REG_W    = 5,
    parameter int unsigned ZERO_REG = 31
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rn,
    input  logic [REG_W-1:0] id_rm,
    input  logic             id_rn_used,
    input  logic             id_rm_used,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             stall
`ifdef FWD_PERF_CNT_EN
    ,
    output logic [31:0]      stall_cnt,
    output logic [31:0]      fwd_cnt
`endif
);

    localparam logic [REG_W-1:0] ZeroReg = REG_W'(ZERO_REG);

    logic             ex_valid_q, ex_valid_d;
    logic [REG_W-1:0] ex_rd_q, ex_rd_d;
    logic             ex_wr_q, ex_wr_d;
    logic             ex_load_q, ex_load_d;
    logic             mem_valid_q, mem_valid_d;
    logic [REG_W-1:0] mem_rd_q, mem_rd_d;
    logic             mem_wr_q, mem_wr_d;
    logic [1:0]       fwd_a_q, fwd_a_d;
    logic [1:0]       fwd_b_q, fwd_b_d;

    logic             ex_live, mem_live, advance;
    logic [1:0]       sel_a, sel_b;

    // Youngest producer (EX) wins over MEM; XZR is never forwarded.
    function automatic logic [1:0] fwd_sel(input logic used, input logic [REG_W-1:0] src,
                                           input logic ex_l, input logic [REG_W-1:0] ex_rd,
                                           input logic mem_l, input logic [REG_W-1:0] mem_rd);
        logic [1:0] sel;
        sel = 2'd0;
        if (used && (src != ZeroReg)) begin
            if (ex_l && (ex_rd == src)) begin
                sel = 2'd1;
            end else if (mem_l && (mem_rd == src)) begin
                sel = 2'd2;
            end
        end
        return sel;
    endfunction

    always_comb begin
        ex_live  = ex_valid_q & ex_wr_q & (ex_rd_q != ZeroReg);
        mem_live = mem_valid_q & mem_wr_q & (mem_rd_q != ZeroReg);

        stall = id_valid & ex_live & ex_load_q & ~flush &
                ((id_rn_used & (id_rn == ex_rd_q)) | (id_rm_used & (id_rm == ex_rd_q)));
        advance = id_valid & ~stall & ~flush;

        sel_a = fwd_sel(id_rn_used, id_rn, ex_live, ex_rd_q, mem_live, mem_rd_q);
        sel_b = fwd_sel(id_rm_used, id_rm, ex_live, ex_rd_q, mem_live, mem_rd_q);

        mem_valid_d = ex_valid_q;
        mem_rd_d    = ex_rd_q;
        mem_wr_d    = ex_wr_q;

        ex_valid_d = advance;
        ex_rd_d    = ex_rd_q;
        ex_wr_d    = ex_wr_q;
        ex_load_d  = ex_load_q;
        fwd_a_d    = 2'd0;
        fwd_b_d    = 2'd0;
        if (advance) begin
            ex_rd_d   = id_rd;
            ex_wr_d   = id_reg_write;
            ex_load_d = id_mem_read;
            fwd_a_d   = sel_a;
            fwd_b_d   = sel_b;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ex_valid_q  <= 1'b0;
            ex_rd_q     <= '0;
            ex_wr_q     <= 1'b0;
            ex_load_q   <= 1'b0;
            mem_valid_q <= 1'b0;
            mem_rd_q    <= '0;
            mem_wr_q    <= 1'b0;
            fwd_a_q     <= 2'd0;
            fwd_b_q     <= 2'd0;
        end else begin
            ex_valid_q  <= ex_valid_d;
            ex_rd_q     <= ex_rd_d;
            ex_wr_q     <= ex_wr_d;
            ex_load_q   <= ex_load_d;
            mem_valid_q <= mem_valid_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            fwd_a_q     <= fwd_a_d;
            fwd_b_q     <= fwd_b_d;
        end
    end

    assign fwd_a = fwd_a_q;
    assign fwd_b = fwd_b_q;

`ifdef FWD_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] fwd_cnt_q, fwd_cnt_d;

    // Counted once per instruction entering EX, not per forwarded operand.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        fwd_cnt_d   = fwd_cnt_q;
        if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (advance && ((sel_a != 2'd0) || (sel_b != 2'd0)) && (fwd_cnt_q != 32'hFFFF_FFFF)) begin
            fwd_cnt_d = fwd_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            fwd_cnt_q   <= fwd_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign fwd_cnt   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_forward_ctrl.sv
// Directed bench for forward_ctrl: expected selects are queued when an instruction is
// presented and popped after the edge that moves it into EX.
module tb_forward_ctrl;

    logic       clk;
    logic       reset;
    logic       id_valid;
    logic [4:0] id_rn;
    logic [4:0] id_rm;
    logic       id_rn_used;
    logic       id_rm_used;
    logic [4:0] id_rd;
    logic       id_reg_write;
    logic       id_mem_read;
    logic       flush;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
    logic       stall;
`ifdef FWD_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] fwd_cnt;
`endif

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_q[$];

    forward_ctrl #(
        .REG_W    (5),
        .ZERO_REG (31)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .id_valid     (id_valid),
        .id_rn        (id_rn),
        .id_rm        (id_rm),
        .id_rn_used   (id_rn_used),
        .id_rm_used   (id_rm_used),
        .id_rd        (id_rd),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .flush        (flush),
        .fwd_a        (fwd_a),
        .fwd_b        (fwd_b),
        .stall        (stall)
`ifdef FWD_PERF_CNT_EN
        ,
        .stall_cnt    (stall_cnt),
        .fwd_cnt      (fwd_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one decode slot for one cycle; stall is checked mid-cycle, selects after the edge.
    task automatic drive(input logic rst_n, input logic v, input logic [4:0] rn,
                         input logic [4:0] rm, input logic rnu, input logic rmu,
                         input logic [4:0] rd, input logic wr, input logic ld, input logic fl,
                         input logic [1:0] ea, input logic [1:0] eb, input logic es,
                         input string tag);
        logic [3:0] e;
        reset        = rst_n;
        id_valid     = v;
        id_rn        = rn;
        id_rm        = rm;
        id_rn_used   = rnu;
        id_rm_used   = rmu;
        id_rd        = rd;
        id_reg_write = wr;
        id_mem_read  = ld;
        flush        = fl;
        exp_q.push_back({ea, eb});
        @(negedge clk);
        check({tag, ".stall"}, {31'd0, stall}, {31'd0, es});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check({tag, ".fwd_a"}, {30'd0, fwd_a}, {30'd0, e[3:2]});
        check({tag, ".fwd_b"}, {30'd0, fwd_b}, {30'd0, e[1:0]});
    endtask

    task automatic nop(input string tag);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, tag);
    endtask

    initial begin
        // rst_n v rn rm rnu rmu rd wr ld fl  ea eb es
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "rst0");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "rst1");
`ifdef FWD_PERF_CNT_EN
        check("rst.stall_cnt", stall_cnt, 32'd0);
        check("rst.fwd_cnt", fwd_cnt, 32'd0);
`endif
        nop("idle");

        // ADD X1,X2,X3 ; ADD X4,X1,X5
        drive(1, 1, 2, 3, 1, 1, 1, 1, 0, 0, 0, 0, 0, "t1_add1");
        drive(1, 1, 1, 5, 1, 1, 4, 1, 0, 0, 1, 0, 0, "t1_add2");
        drive(1, 1, 1, 1, 0, 0, 6, 1, 0, 0, 0, 0, 0, "t1_unused");
        drive(1, 0, 4, 4, 1, 1, 0, 0, 0, 0, 0, 0, 0, "t1_invalid");
        nop("t1_n0");
        nop("t1_n1");

        // ADD X1 ; independent ; SUB X6,X5,X1
        drive(1, 1, 2, 3, 1, 1, 1, 1, 0, 0, 0, 0, 0, "t2_add");
        drive(1, 1, 9, 10, 1, 1, 8, 1, 0, 0, 0, 0, 0, "t2_indep");
        drive(1, 1, 5, 1, 1, 1, 6, 1, 0, 0, 0, 2, 0, "t2_sub");
        nop("t2_n0");
        nop("t2_n1");

        // LDUR X9,[X2] ; ADD X3,X9,X9 with one stall cycle
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "t3_rst");
        drive(1, 1, 2, 0, 1, 0, 9, 1, 1, 0, 0, 0, 0, "t3_ldur");
        drive(1, 1, 9, 9, 1, 1, 3, 1, 0, 0, 0, 0, 1, "t3_stall");
        drive(1, 1, 9, 9, 1, 1, 3, 1, 0, 0, 2, 2, 0, "t3_fwd");
`ifdef FWD_PERF_CNT_EN
        check("t3.stall_cnt", stall_cnt, 32'd1);
        check("t3.fwd_cnt", fwd_cnt, 32'd1);
`endif
        nop("t3_n0");
        nop("t3_n1");

        // X7 written in both EX and MEM; youngest wins
        drive(1, 1, 2, 3, 1, 1, 7, 1, 0, 0, 0, 0, 0, "t4_x7a");
        drive(1, 1, 4, 5, 1, 1, 7, 1, 0, 0, 0, 0, 0, "t4_x7b");
        drive(1, 1, 7, 6, 1, 1, 10, 1, 0, 0, 1, 0, 0, "t4_use");
        nop("t4_n0");
        nop("t4_n1");

        // XZR is never forwarded and never stalls
        drive(1, 1, 2, 3, 1, 1, 31, 1, 0, 0, 0, 0, 0, "t5_x31");
        drive(1, 1, 31, 31, 1, 1, 4, 1, 0, 0, 0, 0, 0, "t5_use");
        drive(1, 1, 2, 0, 1, 0, 31, 1, 1, 0, 0, 0, 0, "t5_ldx31");
        drive(1, 1, 31, 31, 1, 1, 5, 1, 0, 0, 0, 0, 0, "t5_use_ld");
        nop("t5_n0");
        nop("t5_n1");

        // Flush in the would-be stall cycle; the load still advances to MEM
        drive(1, 1, 2, 0, 1, 0, 9, 1, 1, 0, 0, 0, 0, "t6_ldur");
        drive(1, 1, 9, 9, 1, 1, 3, 1, 0, 1, 0, 0, 0, "t6_flush");
        drive(1, 1, 9, 2, 1, 1, 3, 1, 0, 0, 2, 0, 0, "t6_after");
        nop("t6_n0");
        nop("t6_n1");

        // Reset asserted during a stall cycle
        drive(1, 1, 2, 0, 1, 0, 9, 1, 1, 0, 0, 0, 0, "t7_ldur");
        drive(0, 1, 9, 9, 1, 1, 3, 1, 0, 0, 0, 0, 1, "t7_rst");
        drive(1, 1, 9, 9, 1, 1, 3, 1, 0, 0, 0, 0, 0, "t7_after");
`ifdef FWD_PERF_CNT_EN
        check("t7.stall_cnt", stall_cnt, 32'd0);
        check("t7.fwd_cnt", fwd_cnt, 32'd0);
`endif
        nop("end");

        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
